firebird7_in_gate1_tessent_tdr_w3_sel: RTL and testbench

FIREBIRD7_IN_GATE1_TESSENT_TDR_W3_SEL -- requirements
Module: firebird7_in_gate1_tessent_tdr_w3_sel

---
 rtl/firebird7_in_gate1_tessent_tdr_pkg.sv | 11 +
 rtl/firebird7_in_gate1_tessent_tdr_upd_reg.sv | 16 +
 rtl/firebird7_in_gate1_tessent_tdr_w3_sel.sv | 55 +++++
 tb/tb_firebird7_in_gate1_tessent_tdr_w3_sel.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared field layout of the select/data test data register.
// The select bit sits above the data field and is shifted out last.
package firebird7_in_gate1_tessent_tdr_pkg;
  localparam int TDR_DATA_W = 3;
  localparam int DATA_LSB   = 0;
  localparam int SEL_BIT    = DATA_LSB + TDR_DATA_W;

  function automatic int sel_bit_of(input int data_w);
    return DATA_LSB + data_w;
  endfunction
endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_upd_reg.sv
// Falling-edge update register with async active-low reset to RST_VAL.
module firebird7_in_gate1_tessent_tdr_upd_reg #(
  parameter int            W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         tck,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(negedge tck or negedge rst_n) begin
    if (!rst_n)  q <= RST_VAL;
    else if (en) q <= d;
  end
endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_w3_sel.sv
// IJTAG TDR driving a downstream data mux: select bit plus DATA_WIDTH override bits,
// with half-cycle retimed scan out and falling-edge update registers.
module firebird7_in_gate1_tessent_tdr_w3_sel
  import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
  parameter int                     DATA_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0]  RESET_DATA = '0
) (
  input  logic                  ijtag_tck,
  input  logic                  ijtag_reset,
  input  logic                  ijtag_sel,
  input  logic                  ijtag_ce,
  input  logic                  ijtag_se,
  input  logic                  ijtag_ue,
  input  logic                  ijtag_si,
  output logic                  ijtag_so,
  input  logic [DATA_WIDTH-1:0] observe_data_in,
  output logic                  ijtag_select,
  output logic [DATA_WIDTH-1:0] ijtag_data_out
);
  localparam int SB = sel_bit_of(DATA_WIDTH);

  logic [SB:DATA_LSB] sr;
  logic               upd_en;

  // Capture reports the applied select so software can read back the override state.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset)                sr <= '0;
    else if (ijtag_sel && ijtag_ce)  sr <= {ijtag_select, observe_data_in};
    else if (ijtag_sel && ijtag_se)  sr <= {ijtag_si, sr[SB:DATA_LSB+1]};
  end

  always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) ijtag_so <= 1'b0;
    else              ijtag_so <= sr[DATA_LSB];
  end

  assign upd_en = ijtag_sel & ijtag_ue;

  firebird7_in_gate1_tessent_tdr_upd_reg #(.W(1), .RST_VAL(1'b0)) u_upd_sel (
    .tck   (ijtag_tck),
    .rst_n (ijtag_reset),
    .en    (upd_en),
    .d     (sr[SB]),
    .q     (ijtag_select)
  );

  firebird7_in_gate1_tessent_tdr_upd_reg #(.W(DATA_WIDTH), .RST_VAL(RESET_DATA)) u_upd_data (
    .tck   (ijtag_tck),
    .rst_n (ijtag_reset),
    .en    (upd_en),
    .d     (sr[SB-1:DATA_LSB]),
    .q     (ijtag_data_out)
  );
endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w3_sel.sv
// Scoreboard bench: stimulus queues expected outputs tagged with the falling edge
// at which they must appear; a monitor pops and compares just after each falling edge.
module tb_firebird7_in_gate1_tessent_tdr_w3_sel;
  import firebird7_in_gate1_tessent_tdr_pkg::*;

  logic                  tck = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  sel = 1'b0, ce = 1'b0, se = 1'b0, ue = 1'b0, si = 1'b0;
  logic                  so;
  logic [TDR_DATA_W-1:0] obs = '0;
  logic                  select;
  logic [TDR_DATA_W-1:0] data;

  firebird7_in_gate1_tessent_tdr_w3_sel #(.DATA_WIDTH(TDR_DATA_W), .RESET_DATA('0)) dut (
    .ijtag_tck       (tck),
    .ijtag_reset     (rst_n),
    .ijtag_sel       (sel),
    .ijtag_ce        (ce),
    .ijtag_se        (se),
    .ijtag_ue        (ue),
    .ijtag_si        (si),
    .ijtag_so        (so),
    .observe_data_in (obs),
    .ijtag_select    (select),
    .ijtag_data_out  (data)
  );

  always #5 tck = ~tck;

  typedef struct {
    int                    due;
    bit                    is_so;
    logic [SEL_BIT:0]      outv;
    logic                  sov;
    string                 name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   ncnt  = 0;
  int   tests = 0;
  int   fails = 0;

  always @(negedge tck) begin
    ncnt++;
    #1;
    while (q.size() > 0 && q[0].due <= ncnt) begin
      e = q.pop_front();
      tests++;
      if (e.is_so) begin
        if (e.due != ncnt || so !== e.sov) begin
          fails++;
          $display("FAIL %s: so=%b expected %b (edge %0d due %0d)", e.name, so, e.sov, ncnt, e.due);
        end
      end else begin
        if (e.due != ncnt || {select, data} !== e.outv) begin
          fails++;
          $display("FAIL %s: select/data=%b/%b expected %b/%b (edge %0d due %0d)",
                   e.name, select, data, e.outv[SEL_BIT], e.outv[SEL_BIT-1:0], ncnt, e.due);
        end
      end
    end
  end

  task automatic step(input logic s, input logic c, input logic sh, input logic u, input logic i);
    @(negedge tck);
    #2;
    sel = s; ce = c; se = sh; ue = u; si = i;
  endtask

  task automatic exp_out(input string name, input logic s, input logic [TDR_DATA_W-1:0] d);
    exp_t x;
    x.due = ncnt + 1; x.is_so = 1'b0; x.outv = {s, d}; x.sov = 1'b0; x.name = name;
    q.push_back(x);
  endtask

  task automatic exp_so(input string name, input logic v);
    exp_t x;
    x.due = ncnt + 1; x.is_so = 1'b1; x.outv = '0; x.sov = v; x.name = name;
    q.push_back(x);
  endtask

  logic [3:0] shift_in;
  logic [3:0] so_seq;

  initial begin
    // Reset held with active controls: everything stays cleared.
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1, 1, 1);
      exp_out("rst_out", 1'b0, 3'b000);
      exp_so("rst_so", 1'b0);
    end
    step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    exp_out("rel_out", 1'b0, 3'b000);

    // Shift si = 1,1,0,1 -> register {1,011}; outputs must not move while shifting.
    shift_in = 4'b1011;
    so_seq   = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 1, 0, shift_in[k]);
      exp_out("shift_hold", 1'b0, 3'b000);
      exp_so("shift_so", so_seq[k]);
    end
    step(1, 0, 0, 1, 0);
    exp_out("upd_1011", 1'b1, 3'b011);

    // Capture {applied select=1, 101} and scan it out: 1,0,1,1 then 0.
    obs = 3'b101;
    step(1, 1, 0, 0, 0);
    exp_so("cap_so0", 1'b1);
    so_seq = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 1, 0, 0);
      exp_so("cap_so", so_seq[k]);
      exp_out("cap_hold", 1'b1, 3'b011);
    end

    // Update with the drained register clears the applied select.
    step(1, 0, 0, 1, 0);
    exp_out("upd_zero", 1'b0, 3'b000);

    // ce and se together: capture wins, register {0,010}.
    obs = 3'b010;
    step(1, 1, 1, 0, 1);
    exp_so("cap_pri_so", 1'b0);
    step(1, 0, 0, 1, 0);
    exp_out("cap_pri_upd", 1'b0, 3'b010);
    step(1, 0, 1, 0, 0);
    exp_so("post_cap_shift", 1'b1);

    // sel low: controls toggle, nothing moves (register stays {0,001}).
    obs = 3'b111;
    for (int k = 0; k < 8; k++) begin
      step(0, k[0], k[1], ~k[0], 1);
      exp_out("sel0_out", 1'b0, 3'b010);
      exp_so("sel0_so", 1'b1);
    end
    step(1, 0, 0, 1, 0);
    exp_out("sel0_upd", 1'b0, 3'b001);

    // Two of four shifts, then reset aborts; update afterwards loads zeros.
    step(1, 0, 1, 0, 1);
    exp_so("abort_s1", 1'b0);
    step(1, 0, 1, 0, 1);
    exp_so("abort_s2", 1'b0);
    exp_out("abort_hold", 1'b0, 3'b001);
    step(1, 0, 1, 1, 1);
    #1 rst_n = 1'b0;
    exp_out("abort_rst_out", 1'b0, 3'b000);
    exp_so("abort_rst_so", 1'b0);
    step(1, 0, 1, 1, 1);
    exp_out("abort_rst_hold", 1'b0, 3'b000);
    step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 0, 1, 0);
    exp_out("abort_upd", 1'b0, 3'b000);
    exp_so("abort_upd_so", 1'b0);

    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge tck);
    #3;
    if (q.size() > 0) begin
      tests += q.size();
      fails += q.size();
      $display("FAIL drain: %0d expected entries never checked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
